// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, word type, branch-resolve FSM states and predictor widths.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  localparam int unsigned BHR_WIDTH     = 10;
  localparam int unsigned PHT_IDX_WIDTH = 10;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StBlank    = 2'd2
  } bru_state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage inputs and predictor-update / redirect outputs of the branch resolve unit.
// Counter signals exist only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if;
  import lc3b_types::*;

  logic                     valid_EX;
  lc3b_opcode               opcode_EX;
  lc3b_word                 pc_EX;
  lc3b_word                 pc_plus2_EX;
  logic [2:0]               nzp_EX;
  logic [2:0]               cc;
  lc3b_word                 target_EX;
  logic                     pred_taken_EX;
  lc3b_word                 pred_target_EX;
  logic [BHR_WIDTH-1:0]     history_EX;
  logic                     stall;

  logic                     is_branch_EX_MEM;
  logic                     branched_EX_MEM;
  logic [PHT_IDX_WIDTH-1:0] pc_out_EX_MEM;
  logic [BHR_WIDTH-1:0]     branch_history_EX_MEM;
  lc3b_word                 branch_address_EX_MEM;
  logic                     redirect;
  lc3b_word                 redirect_pc;
  logic                     flush_IF_ID;
  logic                     flush_ID_EX;
`ifdef BRU_PERF_CNT_EN
  logic [15:0]              branch_count;
  logic [15:0]              mispredict_count;
`endif

  modport master (
    output valid_EX, opcode_EX, pc_EX, pc_plus2_EX, nzp_EX, cc, target_EX,
           pred_taken_EX, pred_target_EX, history_EX, stall,
`ifdef BRU_PERF_CNT_EN
    input  branch_count, mispredict_count,
`endif
    input  is_branch_EX_MEM, branched_EX_MEM, pc_out_EX_MEM, branch_history_EX_MEM,
           branch_address_EX_MEM, redirect, redirect_pc, flush_IF_ID, flush_ID_EX
  );

  modport slave (
    input  valid_EX, opcode_EX, pc_EX, pc_plus2_EX, nzp_EX, cc, target_EX,
           pred_taken_EX, pred_target_EX, history_EX, stall,
`ifdef BRU_PERF_CNT_EN
    output branch_count, mispredict_count,
`endif
    output is_branch_EX_MEM, branched_EX_MEM, pc_out_EX_MEM, branch_history_EX_MEM,
           branch_address_EX_MEM, redirect, redirect_pc, flush_IF_ID, flush_ID_EX
  );

endinterface

// File: rtl/branch_compare.sv
// Combinational direction/target resolution of a control-flow instruction in EX.
module branch_compare
  import lc3b_types::*;
(
  input  lc3b_opcode opcode_i,
  input  logic [2:0] nzp_i,
  input  logic [2:0] cc_i,
  input  logic       pred_taken_i,
  input  lc3b_word   pred_target_i,
  input  lc3b_word   target_i,
  output logic       is_ctrl_o,
  output logic       taken_o,
  output logic       mispredict_o
);

  always_comb begin
    is_ctrl_o = 1'b0;
    taken_o   = 1'b0;
    case (opcode_i)
      op_br: begin
        is_ctrl_o = 1'b1;
        taken_o   = |(nzp_i & cc_i);
      end
      op_jmp, op_jsr, op_trap: begin
        is_ctrl_o = 1'b1;
        taken_o   = 1'b1;
      end
      default: ;
    endcase
    // A correct direction still mispredicts when a taken target is wrong.
    mispredict_o = (pred_taken_i != taken_o) ||
                   (pred_taken_i && taken_o && (pred_target_i != target_i));
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches in EX, emits predictor updates and drives the redirect/flush sequence.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
  import lc3b_types::*;
(
  input logic                 clk,
  input logic                 reset,
  branch_resolve_unit_if.slave bus
);

  bru_state_t state_q, state_d;
  logic       is_ctrl, taken, mispredict, resolve;

  logic                     is_branch_q, branched_q;
  logic [PHT_IDX_WIDTH-1:0] pc_out_q;
  logic [BHR_WIDTH-1:0]     history_q;
  lc3b_word                 address_q, redirect_pc_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_EX[15:11], bus.pc_EX[0]};

  branch_compare u_compare (
    .opcode_i      (bus.opcode_EX),
    .nzp_i         (bus.nzp_EX),
    .cc_i          (bus.cc),
    .pred_taken_i  (bus.pred_taken_EX),
    .pred_target_i (bus.pred_target_EX),
    .target_i      (bus.target_EX),
    .is_ctrl_o     (is_ctrl),
    .taken_o       (taken),
    .mispredict_o  (mispredict)
  );

  // Only IDLE accepts work; anything seen during the flush is wrong-path.
  assign resolve = (state_q == StIdle) && bus.valid_EX && !bus.stall && is_ctrl;

  always_comb begin
    state_d         = state_q;
    bus.redirect    = 1'b0;
    bus.flush_IF_ID = 1'b0;
    bus.flush_ID_EX = 1'b0;
    case (state_q)
      StIdle: begin
        if (resolve && mispredict) state_d = StRedirect;
      end
      StRedirect: begin
        bus.redirect    = 1'b1;
        bus.flush_IF_ID = 1'b1;
        bus.flush_ID_EX = 1'b1;
        if (!bus.stall) state_d = StBlank;
      end
      StBlank: begin
        bus.flush_ID_EX = 1'b1;
        if (!bus.stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      is_branch_q   <= 1'b0;
      branched_q    <= 1'b0;
      pc_out_q      <= '0;
      history_q     <= '0;
      address_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      is_branch_q <= resolve;
      if (resolve) begin
        branched_q <= taken;
        pc_out_q   <= bus.pc_EX[10:1];
        history_q  <= bus.history_EX;
        address_q  <= bus.target_EX;
        if (mispredict) redirect_pc_q <= taken ? bus.target_EX : bus.pc_plus2_EX;
      end
    end
  end

  assign bus.is_branch_EX_MEM      = is_branch_q;
  assign bus.branched_EX_MEM       = branched_q;
  assign bus.pc_out_EX_MEM         = pc_out_q;
  assign bus.branch_history_EX_MEM = history_q;
  assign bus.branch_address_EX_MEM = address_q;
  assign bus.redirect_pc           = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
  logic [15:0] branch_count_q, mispredict_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (resolve) begin
      if (branch_count_q != 16'hFFFF) branch_count_q <= branch_count_q + 16'd1;
      if (mispredict && (mispredict_count_q != 16'hFFFF)) begin
        mispredict_count_q <= mispredict_count_q + 16'd1;
      end
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs from the EX stage:
- `valid_EX`, 1 bit.
- `opcode_EX`, lc3b_opcode.
- `pc_EX`, lc3b_word.
- `pc_plus2_EX`, lc3b_word.
- `nzp_EX`, 3 bits.
- `cc`, 3 bits.
- `target_EX`, lc3b_word.
- `pred_taken_EX`, 1 bit.
- `pred_target_EX`, lc3b_word.
- `history_EX`, 10 bits.
REQ-004 SHALL have input `stall`, 1 bit: a pipeline freeze (memory wait).
REQ-005 SHALL have predictor-update outputs, all registered:
- `is_branch_EX_MEM`, 1 bit.
- `branched_EX_MEM`, 1 bit.
- `pc_out_EX_MEM`, 10 bits.
- `branch_history_EX_MEM`, 10 bits.
- `branch_address_EX_MEM`, lc3b_word.
REQ-006 SHALL have redirect/flush outputs:
- `redirect`, 1 bit.
- `redirect_pc`, lc3b_word.
- `flush_IF_ID`, 1 bit.
- `flush_ID_EX`, 1 bit.
REQ-007 SHALL have outputs `branch_count` and `mispredict_count`, 16 bits each; present only under REQ-024.

Function
REQ-008 A resolution event SHALL occur when all of the following hold: state IDLE, valid_EX=1, stall=0, and opcode_EX is op_br, op_jmp, op_jsr or op_trap.
REQ-009 Actual direction SHALL be |(nzp_EX & cc) for op_br, and 1 for op_jmp, op_jsr and op_trap.
REQ-010 Mispredict SHALL be asserted when:
- predicted and actual direction differ, or
- both are taken and pred_target_EX != target_EX.
REQ-011 On every resolution event, the update outputs SHALL be driven on the next rising edge:
- is_branch_EX_MEM=1.
- branched_EX_MEM = actual direction.
- pc_out_EX_MEM = pc_EX[10:1].
- branch_history_EX_MEM = history_EX.
- branch_address_EX_MEM = target_EX.
REQ-012 is_branch_EX_MEM SHALL be a single-cycle pulse; it is 0 in every cycle not following a resolution event.
REQ-013 The FSM SHALL have states IDLE, REDIRECT and BLANK.
REQ-014 A resolution event with mispredict SHALL move IDLE to REDIRECT and latch redirect_pc:
- target_EX if the actual direction is taken,
- pc_plus2_EX otherwise.
REQ-015 In REDIRECT:
- redirect=1, flush_IF_ID=1, flush_ID_EX=1.
- Exit to BLANK when stall=0; hold REDIRECT while stall=1.
REQ-016 In BLANK:
- flush_ID_EX=1, redirect=0.
- Exit to IDLE when stall=0.
REQ-017 In IDLE, redirect, flush_IF_ID and flush_ID_EX SHALL all be 0.
REQ-018 Inputs presented while the state is not IDLE are wrong-path and SHALL be ignored: no update pulse, no counter change.
REQ-019 Minimum misprediction penalty: redirect asserted exactly 1 cycle after the resolving edge, and IDLE regained 2 cycles after it when stall=0.
REQ-020 redirect_pc SHALL hold its latched value until the next mispredict.

Reset
REQ-021 While reset=1:
- state SHALL become IDLE.
- All update outputs SHALL be 0.
- redirect, flush_IF_ID and flush_ID_EX SHALL be 0.
- redirect_pc SHALL be 16'h0000.
- Counters SHALL be 0.
REQ-022 Reset asserted in REDIRECT or BLANK SHALL abort the flush: no further redirect is issued.
REQ-023 Reset SHALL take priority over stall and over a simultaneous resolution event.

Configuration
REQ-024 Macro BRU_PERF_CNT_EN:
- When defined: branch_count increments on every resolution event, and mispredict_count on every mispredicting event. Both saturate at 16'hFFFF.
- When undefined: neither the ports nor the counter logic exist.

Structure
REQ-025 The shared lc3b_types package SHALL hold:
- the branch-resolve state enum (bru_state_t),
- the history width constant BHR_WIDTH=10,
- the predictor index width constant PHT_IDX_WIDTH=10.
REQ-026 The direction/target comparison SHALL be a sub-module branch_compare (combinational), instantiated once; the FSM and registers stay in branch_resolve_unit.

Verification
REQ-027 Correctly predicted br: cc=3'b010, nzp=3'b010, pred_taken=1, pred_target=target=16'h0040, pc=16'h0020, history=10'h155.
- Next cycle: is_branch=1, branched=1, pc_out=10'h010, history=10'h155, address=16'h0040.
- redirect and flush stay 0.
REQ-028 Not-taken mispredict: br with nzp=3'b100, cc=3'b001, pred_taken=1, pc_plus2=16'h0032.
- Next cycle: redirect=1, redirect_pc=16'h0032, both flushes=1.
- Following cycle: BLANK (flush_ID_EX only).
- Then IDLE.
REQ-029 Target mismatch: jmp, pred_taken=1, pred_target=16'h0100, target=16'h0200.
- Result: mispredict, redirect_pc=16'h0200, branched=1.
REQ-030 Stall and wrong-path: stall=1 for 3 cycles during REDIRECT.
- redirect stays 1 for 4 cycles.
- A valid op_br in EX during this window yields no update pulse.
REQ-031 Reset mid-flush: reset asserted in BLANK.
- Next cycle: IDLE, all outputs 0.
- With BRU_PERF_CNT_EN: 70000 resolutions leave branch_count=16'hFFFF.
